// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and spine field offsets for the spine controller
package tt_pkg;

    localparam int SEL_W = 10;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2
    } ena_state_t;

    // Fixed low-order field positions; the user fields sit above these.
    localparam int IW_GL     = 0;
    localparam int IW_ENA    = 1;
    localparam int IW_SEL_LO = 2;
    localparam int IW_USR_LO = IW_SEL_LO + SEL_W;
    localparam int OW_USR_LO = 1;

endpackage

// File: rtl/tt_sync_edge.sv
// rtl/tt_sync_edge.sv - multi-flop synchroniser with reset value and rising-edge pulse
module tt_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            q_d   <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~q_d;

endmodule

// File: rtl/tt_spine_ctrl.sv
// rtl/tt_spine_ctrl.sv - spine select/enable sequencer and pad mux (option: TT_SPINE_CTRL_OUTREG_EN)
module tt_spine_ctrl
    import tt_pkg::*;
#(
    parameter int N_IO        = 8,
    parameter int N_O         = 8,
    parameter int N_I         = 10,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD       = 4,
    parameter int S_OW        = N_O + 2 * N_IO + 2,
    parameter int S_IW        = N_I + N_IO + 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pad_sel_rst_n,
    input  logic              pad_sel_inc,
    input  logic              pad_ena,
    input  logic [N_I-1:0]    pad_ui_in,
    input  logic [N_IO-1:0]   pad_uio_in,
    output logic [N_O-1:0]    pad_uo_out,
    output logic [N_IO-1:0]   pad_uio_out,
    output logic [N_IO-1:0]   pad_uio_oe,
    output logic [S_IW-1:0]   spine_iw,
    input  logic [S_OW-1:0]   spine_ow,
    output logic [SEL_W-1:0]  cur_sel
);

    localparam int UIO_OE_LO  = OW_USR_LO;
    localparam int UIO_OUT_LO = OW_USR_LO + N_IO;
    localparam int UO_LO      = OW_USR_LO + 2 * N_IO;

    logic sel_rst_n_s, inc_s, ena_s, inc_rise;
    logic unused_rst_rise, unused_ena_rise, unused_inc_s, unused_ow_guard;

    tt_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rst (
        .clk(clk), .rst(rst), .d(pad_sel_rst_n), .q(sel_rst_n_s), .rise(unused_rst_rise)
    );
    tt_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_inc (
        .clk(clk), .rst(rst), .d(pad_sel_inc), .q(inc_s), .rise(inc_rise)
    );
    tt_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ena (
        .clk(clk), .rst(rst), .d(pad_ena), .q(ena_s), .rise(unused_ena_rise)
    );

    assign unused_inc_s    = inc_s;
    assign unused_ow_guard = ^{spine_ow[S_OW-1], spine_ow[0]};

    logic [SEL_W-1:0] sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel <= '0;
        else if (!sel_rst_n_s)
            sel <= '0;
        else if (inc_rise)
            sel <= sel + 10'd1;
    end

    assign cur_sel = sel;

    ena_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Losing enable or select-reset wins over everything; any increment restarts the guard.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!ena_s || !sel_rst_n_s) begin
            state_nxt = ST_OFF;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = 4'(GUARD);
                end
                ST_SETTLE: begin
                    if (inc_rise)
                        cnt_nxt = 4'(GUARD);
                    else if (cnt == 4'd1)
                        state_nxt = ST_ON;
                    else
                        cnt_nxt = cnt - 4'd1;
                end
                ST_ON: begin
                    if (inc_rise) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = 4'(GUARD);
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        on = (state == ST_ON);
    end

    always_comb begin
        spine_iw                          = '0;
        spine_iw[IW_ENA]                  = on;
        spine_iw[IW_SEL_LO +: SEL_W]      = sel;
        spine_iw[IW_USR_LO +: N_I + N_IO] = on ? {pad_ui_in, pad_uio_in} : '0;
    end

`ifdef TT_SPINE_CTRL_OUTREG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_uo_out  <= '0;
            pad_uio_out <= '0;
            pad_uio_oe  <= '0;
        end else begin
            pad_uo_out  <= on ? spine_ow[UO_LO +: N_O]       : '0;
            pad_uio_out <= on ? spine_ow[UIO_OUT_LO +: N_IO] : '0;
            pad_uio_oe  <= on ? spine_ow[UIO_OE_LO +: N_IO]  : '0;
        end
    end
`else
    assign pad_uo_out  = on ? spine_ow[UO_LO +: N_O]       : '0;
    assign pad_uio_out = on ? spine_ow[UIO_OUT_LO +: N_IO] : '0;
    assign pad_uio_oe  = on ? spine_ow[UIO_OE_LO +: N_IO]  : '0;
`endif

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// tb/tb_tt_spine_ctrl.sv - directed self-checking bench for tt_spine_ctrl
module tb_tt_spine_ctrl;

    logic        clk;
    logic        rst;
    logic        pad_sel_rst_n;
    logic        pad_sel_inc;
    logic        pad_ena;
    logic [9:0]  pad_ui_in;
    logic [7:0]  pad_uio_in;
    logic [7:0]  pad_uo_out;
    logic [7:0]  pad_uio_out;
    logic [7:0]  pad_uio_oe;
    logic [30:0] spine_iw;
    logic [25:0] spine_ow;
    logic [9:0]  cur_sel;

    int total = 0;
    int bad   = 0;

    tt_spine_ctrl dut (
        .clk(clk), .rst(rst),
        .pad_sel_rst_n(pad_sel_rst_n), .pad_sel_inc(pad_sel_inc), .pad_ena(pad_ena),
        .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
        .pad_uo_out(pad_uo_out), .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe),
        .spine_iw(spine_iw), .spine_ow(spine_ow), .cur_sel(cur_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; pad_sel_rst_n = 1'b0; pad_sel_inc = 1'b0; pad_ena = 1'b0;
        pad_ui_in = 10'h2A5; pad_uio_in = 8'h3C;
        spine_ow = {1'b1, 8'h5A, 8'hC3, 8'h0F, 1'b1};
        tick(3);
        total++; if (cur_sel !== 10'd0) begin bad++; $display("FAIL reset_sel got=%h exp=%h", cur_sel, 10'd0); end
        total++; if (spine_iw !== 31'd0) begin bad++; $display("FAIL reset_iw got=%h exp=%h", spine_iw, 31'd0); end
        total++; if (pad_uo_out !== 8'd0) begin bad++; $display("FAIL reset_uo got=%h exp=%h", pad_uo_out, 8'd0); end
        total++; if (pad_uio_oe !== 8'd0) begin bad++; $display("FAIL reset_oe got=%h exp=%h", pad_uio_oe, 8'd0); end
    endtask

    task automatic test_enable;
        rst = 1'b0; pad_sel_rst_n = 1'b1; pad_ena = 1'b1;
        tick(6);
        total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL en_early got=%b exp=%b", spine_iw[1], 1'b0); end
        tick(1);
        total++; if (spine_iw !== {1'b0, 10'h2A5, 8'h3C, 10'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL en_iw got=%h exp=%h", spine_iw, {1'b0, 10'h2A5, 8'h3C, 10'd0, 1'b1, 1'b0}); end
        tick(2);
        total++; if (pad_uo_out !== 8'h5A) begin bad++; $display("FAIL en_uo got=%h exp=%h", pad_uo_out, 8'h5A); end
        total++; if (pad_uio_out !== 8'hC3) begin bad++; $display("FAIL en_uio got=%h exp=%h", pad_uio_out, 8'hC3); end
        total++; if (pad_uio_oe !== 8'h0F) begin bad++; $display("FAIL en_oe got=%h exp=%h", pad_uio_oe, 8'h0F); end
    endtask

    task automatic test_increment;
        for (int k = 1; k <= 5; k++) begin
            pad_sel_inc = 1'b1;
            tick(2);
            total++; if (cur_sel !== 10'(k - 1)) begin bad++; $display("FAIL inc_pre%0d got=%0d exp=%0d", k, cur_sel, k - 1); end
            total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL inc_on_pre%0d got=%b exp=%b", k, spine_iw[1], 1'b1); end
            tick(1);
            total++; if (cur_sel !== 10'(k)) begin bad++; $display("FAIL inc_sel%0d got=%0d exp=%0d", k, cur_sel, k); end
            total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL inc_drop%0d got=%b exp=%b", k, spine_iw[1], 1'b0); end
            tick(1);
            pad_sel_inc = 1'b0;
            tick(2);
            total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL inc_guard%0d got=%b exp=%b", k, spine_iw[1], 1'b0); end
            tick(1);
            total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL inc_back%0d got=%b exp=%b", k, spine_iw[1], 1'b1); end
            tick(1);
        end
        total++; if (cur_sel !== 10'd5) begin bad++; $display("FAIL inc_final got=%0d exp=%0d", cur_sel, 5); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 1018; k++) begin
            pad_sel_inc = 1'b1; tick(3);
            pad_sel_inc = 1'b0; tick(3);
        end
        tick(8);
        total++; if (cur_sel !== 10'd1023) begin bad++; $display("FAIL wrap_max got=%0d exp=%0d", cur_sel, 1023); end
        total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL wrap_on got=%b exp=%b", spine_iw[1], 1'b1); end
        pad_sel_inc = 1'b1;
        tick(3);
        total++; if (cur_sel !== 10'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=%0d", cur_sel, 0); end
        total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL wrap_settle got=%b exp=%b", spine_iw[1], 1'b0); end
        tick(1);
        pad_sel_inc = 1'b0;
        tick(3);
        total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL wrap_back got=%b exp=%b", spine_iw[1], 1'b1); end
    endtask

    task automatic test_sel_rst;
        for (int k = 0; k < 2; k++) begin
            pad_sel_inc = 1'b1; tick(3);
            pad_sel_inc = 1'b0; tick(3);
        end
        tick(8);
        total++; if (cur_sel !== 10'd2) begin bad++; $display("FAIL srst_pre got=%0d exp=%0d", cur_sel, 2); end
        pad_sel_rst_n = 1'b0;
        tick(2);
        total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL srst_hold got=%b exp=%b", spine_iw[1], 1'b1); end
        tick(1);
        total++; if (cur_sel !== 10'd0) begin bad++; $display("FAIL srst_sel got=%0d exp=%0d", cur_sel, 0); end
        total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL srst_off got=%b exp=%b", spine_iw[1], 1'b0); end
        tick(1);
        total++; if (pad_uio_oe !== 8'd0) begin bad++; $display("FAIL srst_oe got=%h exp=%h", pad_uio_oe, 8'd0); end
        pad_sel_inc = 1'b1; tick(4);
        pad_sel_inc = 1'b0; tick(4);
        total++; if (cur_sel !== 10'd0) begin bad++; $display("FAIL srst_noinc got=%0d exp=%0d", cur_sel, 0); end
        pad_sel_rst_n = 1'b1;
        tick(6);
        total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL srst_early got=%b exp=%b", spine_iw[1], 1'b0); end
        tick(1);
        total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL srst_back got=%b exp=%b", spine_iw[1], 1'b1); end
    endtask

    task automatic test_ena_settle;
        tick(2);
        pad_sel_inc = 1'b1;
        tick(3);
        total++; if (cur_sel !== 10'd1) begin bad++; $display("FAIL es_sel got=%0d exp=%0d", cur_sel, 1); end
        pad_ena = 1'b0;
        spine_ow = 26'h2AAAAAA;
        tick(1);
        pad_sel_inc = 1'b0;
        tick(6);
        total++; if (spine_iw !== 31'h4) begin bad++; $display("FAIL es_iw got=%h exp=%h", spine_iw, 31'h4); end
        total++; if (pad_uo_out !== 8'd0) begin bad++; $display("FAIL es_uo got=%h exp=%h", pad_uo_out, 8'd0); end
        total++; if (pad_uio_out !== 8'd0) begin bad++; $display("FAIL es_uio got=%h exp=%h", pad_uio_out, 8'd0); end
        total++; if (pad_uio_oe !== 8'd0) begin bad++; $display("FAIL es_oe got=%h exp=%h", pad_uio_oe, 8'd0); end
        pad_ena = 1'b1;
        tick(6);
        total++; if (spine_iw[1] !== 1'b0) begin bad++; $display("FAIL es_early got=%b exp=%b", spine_iw[1], 1'b0); end
        tick(1);
        total++; if (spine_iw[1] !== 1'b1) begin bad++; $display("FAIL es_back got=%b exp=%b", spine_iw[1], 1'b1); end
        tick(1);
        total++; if (pad_uo_out !== 8'h55) begin bad++; $display("FAIL es_uo_on got=%h exp=%h", pad_uo_out, 8'h55); end
        total++; if (pad_uio_out !== 8'h55) begin bad++; $display("FAIL es_uio_on got=%h exp=%h", pad_uio_out, 8'h55); end
        total++; if (pad_uio_oe !== 8'h55) begin bad++; $display("FAIL es_oe_on got=%h exp=%h", pad_uio_oe, 8'h55); end
    endtask

    task automatic test_outreg;
        spine_ow = {1'b0, 8'h00, 8'h55, 8'h55, 1'b0};
        tick(2);
        total++; if (pad_uo_out !== 8'h00) begin bad++; $display("FAIL oreg_zero got=%h exp=%h", pad_uo_out, 8'h00); end
        spine_ow = {1'b0, 8'h5A, 8'h55, 8'h55, 1'b0};
        #1;
`ifdef TT_SPINE_CTRL_OUTREG_EN
        total++; if (pad_uo_out !== 8'h00) begin bad++; $display("FAIL oreg_hold got=%h exp=%h", pad_uo_out, 8'h00); end
        tick(1);
        total++; if (pad_uo_out !== 8'h5A) begin bad++; $display("FAIL oreg_late got=%h exp=%h", pad_uo_out, 8'h5A); end
`else
        total++; if (pad_uo_out !== 8'h5A) begin bad++; $display("FAIL oreg_comb got=%h exp=%h", pad_uo_out, 8'h5A); end
        tick(1);
`endif
    endtask

    task automatic test_async_rst;
        tick(1);
        #2 rst = 1'b1;
        #1;
        total++; if (spine_iw !== 31'd0) begin bad++; $display("FAIL arst_iw got=%h exp=%h", spine_iw, 31'd0); end
        total++; if (cur_sel !== 10'd0) begin bad++; $display("FAIL arst_sel got=%0d exp=%0d", cur_sel, 0); end
        total++; if (pad_uo_out !== 8'd0) begin bad++; $display("FAIL arst_uo got=%h exp=%h", pad_uo_out, 8'd0); end
        total++; if (pad_uio_oe !== 8'd0) begin bad++; $display("FAIL arst_oe got=%h exp=%h", pad_uio_oe, 8'd0); end
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_enable;
        test_increment;
        test_wrap;
        test_sel_rst;
        test_ena_settle;
        test_outreg;
        test_async_rst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
